uart_probe_logger: RTL and testbench
====================================

Name: uart_probe_logger

Overview:
- Debug logger: on each rising edge of a trigger, captures a 32-bit probe word and streams it out over a UART TX line as 4 bytes.
- Bytes are staged in an internal byte FIFO, so bursts of triggers are buffered.
- Overflow is counted, not silently lost.
- Sits between on-chip debug probes and an external UART terminal; the rx line is reserved for future commands.

Parameters:
- CLK_FREQ_HZ, 100_000_000, clock frequency.
- BAUD, 2_000_000, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (50 at defaults), must be >= 4.
- FIFO_DEPTH, 16, byte FIFO entries, power of two, >= 4.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  asynchronous, active-high reset.
- debug_probe_i  in  32  probe data, sampled on the trigger edge.
- debug_trig_i  in  1  trigger level, synchronous to clk_i.
- rx  in  1  UART receive; double-flop synchronized, otherwise ignored.
- tx  out  1  UART transmit, 8N1, idle high.
- overflow_o  out  1  sticky; set when any word is dropped, cleared only by reset.
- drop_cnt_o  out  8  count of dropped words, saturates at 255.

Behaviour:
- Reset values (async, rst_i=1):
  - tx=1, overflow_o=0, drop_cnt_o=0.
  - FIFO empty, writer idle, transmitter IDLE, trig history register=0.
  - Asserting reset mid-frame aborts the frame and forces tx=1 immediately.
- Trigger:
  - trig_q registers debug_trig_i each cycle; an event is debug_trig_i=1 and trig_q=0.
  - A held-high trigger produces exactly one event.
  - debug_probe_i is captured in the event cycle.
- Writer, states IDLE and WRITE:
  - On an event in IDLE with FIFO free entries >= 4: latch the word, go to WRITE, push bytes [31:24], [23:16], [15:8], [7:0] on 4 consecutive cycles, return to IDLE.
  - On an event with free entries < 4, or an event while in WRITE: drop the whole word (no partial words ever), set overflow_o, increment drop_cnt_o (saturating).
- FIFO:
  - Synchronous byte FIFO, FIFO_DEPTH entries, with count/free tracking.
  - Simultaneous push and pop in one cycle is legal; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full cannot occur, because the writer guards with free >= 4.
- Transmitter, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. When FIFO non-empty, pop one byte into the shift register (entry freed that cycle), go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Byte time is 10*CLKS_PER_BIT cycles (500 at defaults).
  - Back-to-back bytes: the next pop happens in the IDLE cycle directly after STOP, so the inter-byte gap is 1 cycle.
- Latency: first start-bit edge on tx within 4 cycles of the trigger event when the FIFO is empty and the transmitter is idle.
- rx: synchronized only; no effect on any output.

Decomposition:
- Package uart_probe_logger_pkg:
  - writer state enum (IDLE, WRITE);
  - transmitter state enum (IDLE, START, DATA, STOP);
  - constant BYTES_PER_WORD=4.
- One natural sub-module: uart_tx_8n1, the baud counter plus shift register, with a valid/ready byte input; ready is high only in IDLE.
- The FIFO and writer stay inline in the top module.

Test Plan:
- Reset: hold rst_i=1 for 10 cycles, then release -> tx=1 continuously, overflow_o=0, drop_cnt_o=0, no activity for 1000 cycles.
- Single capture: probe=0x0000ABCD, trig high for 76 cycles -> tx frames bytes 0x00, 0x00, 0xAB, 0xCD (0xCD on the wire: 0,1,0,1,1,0,0,1,1,1), each 500 cycles; exactly one word sent despite the long trigger pulse.
- Periodic stream: 10 random 16-bit probes, trigger 76 cycles wide every 1976 cycles -> all 40 bytes decoded correctly and in order; overflow_o stays 0.
- Overflow: 6 single-cycle triggers spaced 10 cycles, probes 0x11111111..0x66666666 -> words 1-4 transmitted, words 5-6 dropped, drop_cnt_o=2, overflow_o=1.
- Retrigger during WRITE: two events 2 cycles apart -> second word dropped, drop_cnt_o increments by 1, first word intact.
- Reset mid-frame: assert rst_i during DATA of byte 2 -> tx=1 in the same cycle, FIFO empty after release, and the next trigger sends a clean 4-byte frame.

Source files
------------

// File: rtl/uart_probe_logger_pkg.sv
// rtl/uart_probe_logger_pkg.sv - shared state types and constants for the probe logger
package uart_probe_logger_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    WR_IDLE,
    WR_WRITE
  } wr_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter with a valid/ready byte input
module uart_tx_8n1
  import uart_probe_logger_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit_done;

  assign bit_done = (cnt_q == CNT_LAST);

  // tx decoded from registered state so reset drives the line high at once
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    s_tready = 1'b0;
    tx       = 1'b1;
    case (state_q)
      TX_IDLE: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          shift_d = s_tdata;
          cnt_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        tx    = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (bit_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx    = shift_q[0];
        cnt_d = cnt_q + 1'b1;
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_done) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/uart_probe_logger.sv
// rtl/uart_probe_logger.sv - captures a probe word per trigger edge and streams it out over UART
module uart_probe_logger
  import uart_probe_logger_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 2_000_000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] debug_probe_i,
  input  logic        debug_trig_i,
  input  logic        rx,
  output logic        tx,
  output logic        overflow_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PUSH_LIMIT = CW'(FIFO_DEPTH - BYTES_PER_WORD);
  localparam logic [1:0]    LAST_IDX   = 2'(BYTES_PER_WORD - 1);

  logic          trig_q, trig_d;
  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic          unused_rx;
  wr_state_e     wr_q, wr_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    idx_q, idx_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          trig_event, room, push, pop;
  logic [7:0]    push_data;
  logic          fifo_tvalid, fifo_tready;

  assign trig_d     = debug_trig_i;
  assign rx_meta_d  = rx;
  assign rx_sync_d  = rx_meta_q;
  assign unused_rx  = rx_sync_q;
  assign trig_event = debug_trig_i & ~trig_q;
  assign room       = (count_q <= PUSH_LIMIT);

  // Writer: reserves room for a whole word before accepting it, so words never split
  always_comb begin
    wr_d       = wr_q;
    word_d     = word_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    push       = 1'b0;
    push_data  = word_q[31:24];
    case (wr_q)
      WR_IDLE: begin
        if (trig_event && room) begin
          word_d = debug_probe_i;
          idx_d  = '0;
          wr_d   = WR_WRITE;
        end
      end
      WR_WRITE: begin
        push   = 1'b1;
        word_d = {word_q[23:0], 8'h00};
        idx_d  = idx_q + 2'd1;
        if (idx_q == LAST_IDX) wr_d = WR_IDLE;
      end
      default: wr_d = WR_IDLE;
    endcase
    if (trig_event && ((wr_q == WR_WRITE) || !room)) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  assign fifo_tvalid = (count_q != '0);
  assign pop         = fifo_tvalid & fifo_tready;

  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_q     <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      wr_q       <= WR_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      trig_q     <= trig_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      wr_q       <= wr_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .s_tdata (mem_q[rptr_q]),
    .s_tvalid(fifo_tvalid),
    .s_tready(fifo_tready),
    .tx      (tx)
  );

  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_uart_probe_logger.sv
// tb/tb_uart_probe_logger.sv - directed self-checking bench for uart_probe_logger
module tb_uart_probe_logger;

  localparam int CPB = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] probe = '0;
  logic        trig = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_pass = 0;
  int frame_err = 0;

  always #5 clk = ~clk;

  uart_probe_logger #(
    .CLK_FREQ_HZ(100_000_000),
    .BAUD       (2_000_000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .debug_probe_i(probe),
    .debug_trig_i (trig),
    .rx           (rx),
    .tx           (tx),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  task automatic wait_start(input int timeout, output int lat);
    lat = -1;
    for (int i = 1; i <= timeout; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic recv_byte(input int timeout, output logic [7:0] b, output int lat);
    b = 8'hxx;
    wait_start(timeout, lat);
    if (lat < 0) return;
    repeat (CPB / 2) @(negedge clk);
    if (tx !== 1'b0) frame_err++;
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      b[k] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) frame_err++;
  endtask

  initial begin
    logic [7:0]  b;
    int          lat;
    int          bad;
    logic [7:0]  got [40];
    logic [15:0] vals [10];
    logic [7:0]  want;
    logic [7:0]  w4 [4];

    vals = '{16'h1234, 16'hBEEF, 16'h0001, 16'h8000, 16'hFFFF,
             16'h5AA5, 16'h00FF, 16'hFF00, 16'hC3A7, 16'h7E81};

    // Reset and quiet idle
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_overflow", overflow, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || overflow !== 1'b0 || drop_cnt !== 8'd0) bad++;
    end
    check("idle_1000_cycles", bad, 0);

    // Single capture with a long trigger pulse
    fork
      begin
        probe = 32'h0000ABCD;
        trig  = 1'b1;
        repeat (76) @(negedge clk);
        trig  = 1'b0;
        probe = '0;
      end
      begin
        w4 = '{8'h00, 8'h00, 8'hAB, 8'hCD};
        recv_byte(20, b, lat);
        check("single_latency_le4", (lat >= 1 && lat <= 4), 1);
        check("single_byte0", b, w4[0]);
        for (int i = 1; i < 4; i++) begin
          recv_byte(100, b, lat);
          check($sformatf("single_byte%0d", i), b, w4[i]);
        end
      end
    join
    wait_start(1500, lat);
    check("single_one_word_only", lat, -1);
    check("single_framing", frame_err, 0);

    // Periodic stream of ten words
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          probe = {16'h0000, vals[k]};
          trig  = 1'b1;
          repeat (76) @(negedge clk);
          trig  = 1'b0;
          repeat (1900) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          recv_byte(3000, b, lat);
          got[j] = b;
        end
      end
    join
    for (int j = 0; j < 40; j++) begin
      case (j % 4)
        2:       want = vals[j / 4][15:8];
        3:       want = vals[j / 4][7:0];
        default: want = 8'h00;
      endcase
      check($sformatf("stream_byte%0d", j), got[j], want);
    end
    check("stream_overflow", overflow, 0);
    check("stream_drop_cnt", drop_cnt, 0);
    repeat (100) @(negedge clk);

    // Overflow: six quick triggers, only four fit
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          probe = 32'h11111111 * k;
          trig  = 1'b1;
          @(negedge clk);
          trig  = 1'b0;
          repeat (9) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 16; j++) begin
          recv_byte(3000, b, lat);
          got[j] = b;
        end
      end
    join
    for (int j = 0; j < 16; j++) begin
      want = 8'h11 * 8'(j / 4 + 1);
      check($sformatf("ovf_byte%0d", j), got[j], want);
    end
    wait_start(1500, lat);
    check("ovf_no_extra_bytes", lat, -1);
    check("ovf_drop_cnt", drop_cnt, 2);
    check("ovf_sticky", overflow, 1);

    // Retrigger while the writer is still pushing
    fork
      begin
        probe = 32'hA1B2C3D4;
        trig  = 1'b1;
        @(negedge clk);
        trig  = 1'b0;
        probe = 32'h55667788;
        @(negedge clk);
        trig  = 1'b1;
        @(negedge clk);
        trig  = 1'b0;
      end
      begin
        w4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
          recv_byte(3000, b, lat);
          check($sformatf("retrig_byte%0d", i), b, w4[i]);
        end
      end
    join
    wait_start(1500, lat);
    check("retrig_no_second_word", lat, -1);
    check("retrig_drop_cnt", drop_cnt, 3);

    // Reset in the middle of the second byte's data bits
    fork
      begin
        probe = 32'h12345678;
        trig  = 1'b1;
        @(negedge clk);
        trig  = 1'b0;
      end
      begin
        recv_byte(20, b, lat);
        check("midrst_byte0", b, 8'h12);
      end
    join
    wait_start(100, lat);
    repeat (CPB + CPB / 2) @(negedge clk);
    check("midrst_tx_low_before", tx, 0);
    rst = 1'b1;
    #1;
    check("midrst_tx_high_now", tx, 1);
    check("midrst_drop_cleared", drop_cnt, 0);
    check("midrst_overflow_cleared", overflow, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    wait_start(1500, lat);
    check("midrst_fifo_empty", lat, -1);
    fork
      begin
        probe = 32'hCAFEF00D;
        trig  = 1'b1;
        @(negedge clk);
        trig  = 1'b0;
      end
      begin
        w4 = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        for (int i = 0; i < 4; i++) begin
          recv_byte(3000, b, lat);
          check($sformatf("postrst_byte%0d", i), b, w4[i]);
        end
      end
    join
    check("all_framing", frame_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
